// File: rtl/demux1x4.sv
// Registered 1-to-4 demultiplexer: routes each word by its two top bits to one
// of four lanes, parking it in a one-entry hold buffer while that lane is paused.
module demux1x4 #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  pause_0,
  input  logic                  pause_1,
  input  logic                  pause_2,
  input  logic                  pause_3,
  output logic [DATA_WIDTH-1:0] out_0,
  output logic [DATA_WIDTH-1:0] out_1,
  output logic [DATA_WIDTH-1:0] out_2,
  output logic [DATA_WIDTH-1:0] out_3,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic                  valid_2,
  output logic                  valid_3,
  output logic [CNT_WIDTH-1:0]  cnt_0,
  output logic [CNT_WIDTH-1:0]  cnt_1,
  output logic [CNT_WIDTH-1:0]  cnt_2,
  output logic [CNT_WIDTH-1:0]  cnt_3
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic [3:0]            pause_vec;
  logic [1:0]            in_dest, hold_dest;
  logic                  deliver;
  logic [1:0]            deliver_dest;
  logic [DATA_WIDTH-1:0] deliver_word;

  logic [3:0][DATA_WIDTH-1:0] out_bus;
  logic [3:0]                 valid_bus;
  logic [3:0][CNT_WIDTH-1:0]  cnt_bus;

  assign pause_vec = {pause_3, pause_2, pause_1, pause_0};
  assign in_dest   = in_data[DATA_WIDTH-1:DATA_WIDTH-2];
  assign hold_dest = hold_reg[DATA_WIDTH-1:DATA_WIDTH-2];
  assign in_ready  = (state_reg == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Pause is sampled at the same edge the delivery decision is made, so a
  // lane paused on the accepting edge sends the word to HOLD.
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    deliver      = 1'b0;
    deliver_dest = in_dest;
    deliver_word = in_data;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!pause_vec[in_dest]) begin
            deliver = 1'b1;
          end else begin
            hold_next  = in_data;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        deliver_dest = hold_dest;
        deliver_word = hold_reg;
        if (!pause_vec[hold_dest]) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-lane output registers; out keeps its last word between strobes.
  for (genvar gi = 0; gi < 4; gi++) begin : lane_g
    logic [DATA_WIDTH-1:0] out_reg;
    logic                  valid_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  hit;

    assign hit = deliver && (deliver_dest == 2'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        out_reg   <= '0;
        valid_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        valid_reg <= hit;
        if (hit) begin
          out_reg <= deliver_word;
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end
    end

    assign out_bus[gi]   = out_reg;
    assign valid_bus[gi] = valid_reg;
    assign cnt_bus[gi]   = cnt_reg;
  end

  assign out_0   = out_bus[0];
  assign out_1   = out_bus[1];
  assign out_2   = out_bus[2];
  assign out_3   = out_bus[3];
  assign valid_0 = valid_bus[0];
  assign valid_1 = valid_bus[1];
  assign valid_2 = valid_bus[2];
  assign valid_3 = valid_bus[3];
  assign cnt_0   = cnt_bus[0];
  assign cnt_1   = cnt_bus[1];
  assign cnt_2   = cnt_bus[2];
  assign cnt_3   = cnt_bus[3];

endmodule

// File: tb/tb_demux1x4.sv
// Bench for demux1x4: directed scenarios plus random traffic, every cycle
// compared against a word-level reference model of the lane routing rules.
module tb_demux1x4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] pause = '0;
  logic [9:0] out_0, out_1, out_2, out_3;
  logic       valid_0, valid_1, valid_2, valid_3;
  logic [7:0] cnt_0, cnt_1, cnt_2, cnt_3;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model: a possibly-parked word plus what each lane has seen.
  bit         m_parked = 1'b0;
  logic [9:0] m_parked_word = '0;
  logic [9:0] m_out [4];
  int         m_cnt [4];
  logic [3:0] m_valid = '0;

  always #5 clk = ~clk;

  demux1x4 dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pause_0(pause[0]), .pause_1(pause[1]), .pause_2(pause[2]), .pause_3(pause[3]),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_deliver(input logic [9:0] w);
    int lane;
    lane = int'(w[9:8]);
    m_out[lane]   = w;
    m_valid[lane] = 1'b1;
    m_cnt[lane]   = (m_cnt[lane] + 1) % 256;
    $display("deliver lane=%0d word=%h count=%0d", lane, w, m_cnt[lane]);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input bit rst, input bit v, input logic [9:0] d, input logic [3:0] p);
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d; pause = p;
    #1;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, !rst && !m_parked});

    m_valid = '0;
    if (rst) begin
      m_parked = 1'b0;
      m_parked_word = '0;
      for (int i = 0; i < 4; i++) begin
        m_out[i] = '0;
        m_cnt[i] = 0;
      end
    end else if (m_parked) begin
      if (!p[m_parked_word[9:8]]) begin
        model_deliver(m_parked_word);
        m_parked = 1'b0;
      end
    end else if (v) begin
      if (!p[d[9:8]]) model_deliver(d);
      else begin
        m_parked = 1'b1;
        m_parked_word = d;
      end
    end

    @(posedge clk);
    #1;
    check_eq("valid", {28'd0, valid_3, valid_2, valid_1, valid_0}, {28'd0, m_valid});
    check_eq("out_0", {22'd0, out_0}, {22'd0, m_out[0]});
    check_eq("out_1", {22'd0, out_1}, {22'd0, m_out[1]});
    check_eq("out_2", {22'd0, out_2}, {22'd0, m_out[2]});
    check_eq("out_3", {22'd0, out_3}, {22'd0, m_out[3]});
    check_eq("cnt_0", {24'd0, cnt_0}, 32'(m_cnt[0]));
    check_eq("cnt_1", {24'd0, cnt_1}, 32'(m_cnt[1]));
    check_eq("cnt_2", {24'd0, cnt_2}, 32'(m_cnt[2]));
    check_eq("cnt_3", {24'd0, cnt_3}, 32'(m_cnt[3]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [9:0] fan [4];
    logic [9:0] rw;
    fan[0] = 10'h011; fan[1] = 10'h122; fan[2] = 10'h233; fan[3] = 10'h344;
    for (int i = 0; i < 4; i++) begin
      m_out[i] = '0;
      m_cnt[i] = 0;
    end

    // Reset held with valid traffic present, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'h3FF, 4'h0);
    step(1'b0, 1'b0, 10'h000, 4'h0);

    // Fan-out to all four lanes back to back.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, fan[i], 4'h0);
    step(1'b0, 1'b0, 10'h000, 4'h0);

    // Stall on lane 2 with the next word queued behind it.
    step(1'b0, 1'b1, 10'h2AA, 4'b0100);
    step(1'b0, 1'b1, 10'h0F0, 4'b0100);
    step(1'b0, 1'b1, 10'h0F0, 4'b0100);
    step(1'b0, 1'b1, 10'h0F0, 4'b0000);
    step(1'b0, 1'b1, 10'h0F0, 4'b0000);
    step(1'b0, 1'b0, 10'h000, 4'b0000);

    // A pause on another lane never blocks lane 0 traffic.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'(i + 1), 4'b1000);
    step(1'b0, 1'b0, 10'h000, 4'b1000);

    // Counter wrap on lane 1.
    for (int i = 0; i < 257; i++) step(1'b0, 1'b1, {2'b01, 8'(i)}, 4'h0);
    step(1'b0, 1'b0, 10'h000, 4'h0);

    // Reset while a word is parked: it must never appear.
    step(1'b0, 1'b1, 10'h1C3, 4'b0010);
    step(1'b1, 1'b0, 10'h000, 4'b0010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'h000, 4'b0000);

    // Random traffic with bursty pauses and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rw = 10'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), rw,
           4'($urandom) & 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/demux1x4.md
# demux1x4

Registered 1-to-4 demultiplexer with a one-entry hold buffer, the distribution end of the round-robin datapath. It accepts one 10-bit word per cycle from a single upstream source and routes it to one of four output lanes, using the word's two destination bits. Each lane has its own pause (almost-full) input from its downstream FIFO. When the target lane is paused, the word is parked and upstream is stalled until that lane frees, with no data loss.

## Interface

- DATA_WIDTH, 10, word width; destination field is bits [DATA_WIDTH-1:DATA_WIDTH-2]
- CNT_WIDTH, 8, width of per-lane delivered-word counters

Ports:

- clk  input  1  single clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high; when 1 at posedge, all state returns to reset values
- in_data  input  DATA_WIDTH  word from upstream
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- pause_0 .. pause_3  input  1 each  downstream lane N almost-full; 1 = do not deliver to lane N
- out_0 .. out_3  output  DATA_WIDTH each  registered lane data
- valid_0 .. valid_3  output  1 each  registered one-cycle strobe: out_N carries a new word
- cnt_0 .. cnt_3  output  CNT_WIDTH each  words delivered to lane N, modulo 2^CNT_WIDTH

## Operation

- Reset values:
  - out_N = 0, valid_N = 0, cnt_N = 0
  - hold register = 0, state = IDLE
  - in_ready = 0 while reset is 1
- Destination: dest = in_data[DATA_WIDTH-1:DATA_WIDTH-2], where 0..3 selects lane 0..3. The full word, destination bits included, is forwarded unmodified.
- Accept: a transfer occurs on any posedge where in_valid && in_ready. in_ready = (state == IDLE) && !reset, decoded combinationally from state.
- State IDLE:
  - Accept with pause_dest = 0: out_dest <= in_data, valid_dest <= 1, cnt_dest <= cnt_dest + 1; stay IDLE.
  - Accept with pause_dest = 1: hold <= in_data; go to HOLD; no valid strobe.
  - No accept: all valid_N <= 0.
- State HOLD:
  - in_ready = 0.
  - Each cycle, the block samples pause for the held destination.
  - If that pause = 0: out_dest <= hold, valid_dest <= 1, cnt_dest++, go to IDLE.
  - Otherwise remain in HOLD with all valid_N <= 0.
- Only the held destination's pause matters in HOLD. Pauses on other lanes are ignored.
- In IDLE, a pause on a lane other than the current word's dest never blocks acceptance.
- valid_N is a one-cycle pulse per word. At most one valid_N is high in any cycle.
- out_N holds its last value between words; it is not cleared when valid_N drops.
- Counter arithmetic: unsigned, wraps 2^CNT_WIDTH-1 -> 0. No saturation, no flag.
- Reset mid-operation: a word in HOLD is discarded and never emitted. Counters clear.
- in_valid while reset = 1 is ignored.

## Timing

- Latency, unpaused: word accepted at edge k appears on out_dest with valid_dest = 1 after edge k (visible in cycle k+1).
- Throughput: 1 word/cycle while every addressed lane is unpaused. Back-to-back words to the same lane produce consecutive valid pulses.
- Stall:
  - The word accepted at edge k into HOLD is emitted at the first edge j > k where pause_dest = 0, and is visible after edge j.
  - in_ready returns to 1 in cycle j+1, so the next accept is earliest at edge j+1.
- Pause is sampled at the same edge the delivery decision is made. A lane paused in the same cycle as the accepting edge causes HOLD, not delivery.
- After reset deasserts at edge r, in_ready = 1 in cycle r+1.

## Test plan

- Reset: hold reset 3 cycles with in_valid = 1 and in_data = 0x3FF -> all out_N = 0, valid_N = 0, cnt_N = 0, in_ready = 0 throughout; in_ready = 1 the cycle after release.
- Fan-out: back-to-back words 0x011, 0x122, 0x233, 0x344, no pauses -> valid_0..valid_3 each pulse once on consecutive cycles, 1 cycle after their accepts; out_0=0x011, out_1=0x122, out_2=0x233, out_3=0x344; in_ready stays 1; each cnt_N = 1.
- Stall:
  - Stimulus: pause_2 = 1, send 0x2AA, keep in_valid = 1 with 0x0F0 queued; release pause_2 after 3 cycles.
  - Response: in_ready = 0 for the stall; valid_2 = 1 with out_2 = 0x2AA the cycle after pause_2 is sampled 0; 0x0F0 is accepted the following cycle and appears on out_0 one cycle later.
- Non-blocking pause: pause_3 = 1 constant, stream 5 words with dest 0 -> all 5 delivered on lane 0 at 1/cycle; in_ready never drops.
- Counter wrap: 257 words to lane 1 -> cnt_1 = 0 after word 256, cnt_1 = 1 after word 257; other counters 0.
- Reset during HOLD: pause_1 = 1, send 0x1C3, assert reset 1 cycle, then drop pause_1 -> valid_1 never pulses; cnt_1 = 0; in_ready = 1 the cycle after reset releases.
